// File: rtl/header_parser_fsm.sv
// Receive-path header parser: checks preamble/SFD, captures DA/SA/LT,
// then forwards or drops the fixed-length payload+CRC tail.
module header_parser_fsm #(
  parameter int          PREAMBLE_LEN = 7,
  parameter logic [7:0]  SFD_BYTE     = 8'hD5,
  parameter logic [15:0] EXP_LENGTH   = 16'h002E,
  parameter int          TAIL_LEN     = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        control,
  output logic [7:0]  payload_data,
  output logic        payload_control,
  output logic [47:0] dest_addr,
  output logic [47:0] src_addr,
  output logic [15:0] length_type,
  output logic        header_valid,
  output logic        header_error,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, DA, SA, LT, FWD, DROP
  } state_e;

  localparam logic [5:0] PRE_N     = 6'(PREAMBLE_LEN);
  localparam logic [5:0] TAIL_LAST = 6'(TAIL_LEN - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]  pdata_q, pdata_d;
  logic        pctrl_q, pctrl_d;
  logic [47:0] da_q, da_d;
  logic [47:0] sa_q, sa_d;
  logic [15:0] lt_q, lt_d, lt_full;
  logic        hv_q, hv_d;
  logic        he_q, he_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 6'd1;
    pdata_d = pdata_q;
    pctrl_d = 1'b0;
    da_d    = da_q;
    sa_d    = sa_q;
    lt_d    = lt_q;
    lt_full = {lt_q[7:0], data};
    hv_d    = 1'b0;
    he_d    = 1'b0;
    if (control) begin
      case (state_q)
        IDLE: if (data == 8'h55) begin
          state_d = PRE;
          cnt_d   = 6'd1;
        end
        PRE: begin
          if (data == 8'h55) begin
            if (cnt_inc == PRE_N) begin
              state_d = SFD;
              cnt_d   = 6'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            he_d    = 1'b1;
            state_d = IDLE;
            cnt_d   = 6'd0;
          end
        end
        SFD: begin
          cnt_d = 6'd0;
          if (data == SFD_BYTE) begin
            state_d = DA;
          end else begin
            he_d    = 1'b1;
            state_d = IDLE;
          end
        end
        DA: begin
          da_d  = {da_q[39:0], data};
          cnt_d = cnt_inc;
          if (cnt_q == 6'd5) begin
            state_d = SA;
            cnt_d   = 6'd0;
          end
        end
        SA: begin
          sa_d  = {sa_q[39:0], data};
          cnt_d = cnt_inc;
          if (cnt_q == 6'd5) begin
            state_d = LT;
            cnt_d   = 6'd0;
          end
        end
        LT: begin
          lt_d = lt_full;
          if (cnt_q == 6'd0) begin
            cnt_d = 6'd1;
          end else begin
            // judge the assembled word, not the stale register
            cnt_d = 6'd0;
            if (lt_full == EXP_LENGTH) begin
              hv_d    = 1'b1;
              state_d = FWD;
            end else begin
              he_d    = 1'b1;
              state_d = DROP;
            end
          end
        end
        FWD: begin
          pdata_d = data;
          pctrl_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_q == TAIL_LAST) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
          end
        end
        DROP: begin
          cnt_d = cnt_inc;
          if (cnt_q == TAIL_LAST) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pdata_q <= '0;
      pctrl_q <= 1'b0;
      da_q    <= '0;
      sa_q    <= '0;
      lt_q    <= '0;
      hv_q    <= 1'b0;
      he_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pdata_q <= pdata_d;
      pctrl_q <= pctrl_d;
      da_q    <= da_d;
      sa_q    <= sa_d;
      lt_q    <= lt_d;
      hv_q    <= hv_d;
      he_q    <= he_d;
      busy_q  <= busy_d;
    end
  end

  assign payload_data    = pdata_q;
  assign payload_control = pctrl_q;
  assign dest_addr       = da_q;
  assign src_addr        = sa_q;
  assign length_type     = lt_q;
  assign header_valid    = hv_q;
  assign header_error    = he_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_header_parser_fsm.sv
// Directed bench for header_parser_fsm with a payload scoreboard
// fed at drive time and drained by a strobe monitor.
module tb_header_parser_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        control;
  logic [7:0]  payload_data;
  logic        payload_control;
  logic [47:0] dest_addr;
  logic [47:0] src_addr;
  logic [15:0] length_type;
  logic        header_valid;
  logic        header_error;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  localparam logic [47:0] DA1 = 48'h010203040506;
  localparam logic [47:0] SA1 = 48'h0A0B0C0D0E0F;

  header_parser_fsm dut (
    .clock(clock), .reset(reset), .data(data), .control(control),
    .payload_data(payload_data), .payload_control(payload_control),
    .dest_addr(dest_addr), .src_addr(src_addr),
    .length_type(length_type), .header_valid(header_valid),
    .header_error(header_error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (payload_control === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {40'd0, payload_data}, 48'hFFFF);
      end else begin
        chk("payload_byte", {40'd0, payload_data},
            {40'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input logic [7:0] d, input logic c);
    data    = d;
    control = c;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pd"}, {40'd0, payload_data}, 48'd0);
    chk({tag, "_pc"}, {47'd0, payload_control}, 48'd0);
    chk({tag, "_da"}, dest_addr, 48'd0);
    chk({tag, "_sa"}, src_addr, 48'd0);
    chk({tag, "_lt"}, {32'd0, length_type}, 48'd0);
    chk({tag, "_hv"}, {47'd0, header_valid}, 48'd0);
    chk({tag, "_he"}, {47'd0, header_error}, 48'd0);
    chk({tag, "_busy"}, {47'd0, busy}, 48'd0);
  endtask

  function automatic logic [7:0] fbyte(input int i, input logic [47:0] da,
                                       input logic [47:0] sa,
                                       input logic [15:0] lt);
    logic [7:0] b;
    if (i < 7)       b = 8'h55;
    else if (i == 7) b = 8'hD5;
    else if (i < 14) b = da[47 - 8*(i-8) -: 8];
    else if (i < 20) b = sa[47 - 8*(i-14) -: 8];
    else if (i < 22) b = lt[15 - 8*(i-20) -: 8];
    else             b = 8'(i - 22);
    return b;
  endfunction

  task automatic send_frame(input logic [47:0] da, input logic [47:0] sa,
                            input logic [15:0] lt, input bit gap,
                            input int stop_at);
    bit good;
    good = (lt == 16'h002E);
    for (int i = 0; i < stop_at; i++) begin
      if (good && i >= 22) exp_q.push_back(8'(i - 22));
      step(fbyte(i, da, sa, lt), 1'b1);
      if (i == 0) begin
        chk("busy_rise", {47'd0, busy}, 48'd1);
        chk("no_err_start", {47'd0, header_error}, 48'd0);
      end
      if (i == 21) begin
        chk("hdr_valid", {47'd0, header_valid}, {47'd0, good});
        chk("hdr_error", {47'd0, header_error}, {47'd0, !good});
        chk("dest_addr", dest_addr, da);
        chk("src_addr", src_addr, sa);
        chk("length_type", {32'd0, length_type}, {32'd0, lt});
      end
      if (i == 22) begin
        chk("pulse_end", {46'd0, header_valid, header_error}, 48'd0);
      end
      if (i >= 22) begin
        chk("strobe_now", {47'd0, payload_control}, {47'd0, good});
      end
      if (gap) begin
        step(8'h55, 1'b0);
        chk("gap_no_strobe", {47'd0, payload_control}, 48'd0);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    data    = 8'h00;
    control = 1'b0;
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    chk_zero("reset");
    reset = 1'b0;
    step(8'h00, 1'b0);

    // good continuous frame
    send_frame(DA1, SA1, 16'h002E, 1'b0, 72);
    step(8'h00, 1'b0);
    chk("good_idle", {47'd0, busy}, 48'd0);
    chk("good_drained", 48'(exp_q.size()), 48'd0);

    // bad preamble byte 3, then an immediate clean frame
    step(8'h55, 1'b1);
    step(8'h55, 1'b1);
    step(8'h55, 1'b1);
    step(8'h54, 1'b1);
    chk("pre_err", {47'd0, header_error}, 48'd1);
    chk("pre_err_idle", {47'd0, busy}, 48'd0);
    send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h002E, 1'b0, 72);

    // one 0x55 too many before SFD
    for (int i = 0; i < 8; i++) step(8'h55, 1'b1);
    chk("long_pre_err", {47'd0, header_error}, 48'd1);
    step(8'hD5, 1'b1);
    chk("sfd_ignored_err", {47'd0, header_error}, 48'd0);
    chk("sfd_ignored_busy", {47'd0, busy}, 48'd0);

    // wrong length: error and silent drop
    send_frame(DA1, SA1, 16'h0040, 1'b0, 72);
    chk("drop_lt_held", {32'd0, length_type}, 48'h0040);
    step(8'h00, 1'b0);
    chk("drop_idle", {47'd0, busy}, 48'd0);

    // stalled every other cycle
    send_frame(48'h112233445566, 48'h778899AABBCC, 16'h002E, 1'b1, 72);
    chk("gap_drained", 48'(exp_q.size()), 48'd0);
    chk("gap_idle", {47'd0, busy}, 48'd0);

    // reset after 20 payload bytes
    send_frame(DA1, SA1, 16'h002E, 1'b0, 42);
    reset = 1'b1;
    step(8'h00, 1'b0);
    chk_zero("mid_reset");
    reset = 1'b0;
    for (int i = 42; i < 72; i++) step(8'(i - 22), 1'b1);
    chk("abandon_idle", {47'd0, busy}, 48'd0);
    chk("abandon_drained", 48'(exp_q.size()), 48'd0);
    send_frame(48'hCAFE00BEEF01, SA1, 16'h002E, 1'b0, 72);
    step(8'h00, 1'b0);
    chk("final_drained", 48'(exp_q.size()), 48'd0);
    chk("final_idle", {47'd0, busy}, 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
